// File: rtl/vga_sync_gen_if.sv
// Raster-timing bundle between the sync generator and its consumers (colour stage, connector).
// The master drives the timing outputs; the slave supplies the count enable.
interface vga_sync_gen_if;
   logic       EN;
   logic       HSYNC;
   logic       VSYNC;
   logic       ACTIVE;
   logic       BLANK;
   logic [9:0] X;
   logic [9:0] Y;
   logic       LINE_START;
   logic       FRAME_START;

   modport master (
      input  EN,
      output HSYNC, VSYNC, ACTIVE, BLANK, X, Y, LINE_START, FRAME_START
   );

   modport slave (
      output EN,
      input  HSYNC, VSYNC, ACTIVE, BLANK, X, Y, LINE_START, FRAME_START
   );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator (default 640x480@60): pixel/line counters with registered sync,
// blanking, coordinates and start strobes; outputs lag the counters by one cycle, EN=0 freezes all.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic           CLK,
   input  logic           RST,
   vga_sync_gen_if.master vif
);

   // Totals must fit the 10-bit counters (<= 1024).
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] hcnt, vcnt;
   logic [9:0] hcnt_nxt, vcnt_nxt;

   logic       hs_d, vs_d, act_d, ls_d, fs_d;

   logic       hsync_q, vsync_q, active_q, blank_q, line_start_q, frame_start_q;
   logic [9:0] x_q, y_q;

   always_comb begin
      hcnt_nxt = hcnt + 10'd1;
      vcnt_nxt = vcnt;
      if (hcnt == H_LAST) begin
         hcnt_nxt = '0;
         vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end
   end

   always_comb begin
      act_d = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
      hs_d  = (hcnt >= HS_START) && (hcnt < HS_END);
      vs_d  = (vcnt >= VS_START) && (vcnt < VS_END);
      ls_d  = (hcnt == '0);
      fs_d  = (hcnt == '0) && (vcnt == '0);
   end

   // Counters and output registers advance together, only on enabled edges.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hcnt          <= '0;
         vcnt          <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         active_q      <= 1'b0;
         blank_q       <= 1'b1;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else if (vif.EN) begin
         hcnt          <= hcnt_nxt;
         vcnt          <= vcnt_nxt;
         hsync_q       <= hs_d ? HS_POL : ~HS_POL;
         vsync_q       <= vs_d ? VS_POL : ~VS_POL;
         active_q      <= act_d;
         blank_q       <= ~act_d;
         x_q           <= hcnt;
         y_q           <= vcnt;
         line_start_q  <= ls_d;
         frame_start_q <= fs_d;
      end
   end

   assign vif.HSYNC       = hsync_q;
   assign vif.VSYNC       = vsync_q;
   assign vif.ACTIVE      = active_q;
   assign vif.BLANK       = blank_q;
   assign vif.X           = x_q;
   assign vif.Y           = y_q;
   assign vif.LINE_START  = line_start_q;
   assign vif.FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two small-raster instances (both sync polarities) plus the full 640x480
// instance, driven by shared random EN and mid-frame resets, scored against a pixel-index model.
module tb_vga_sync_gen;

   logic CLK = 1'b0;
   logic RST;
   logic en;
   always #5 CLK = ~CLK;

   localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
   localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       act;
      logic       blank;
      logic [9:0] x;
      logic [9:0] y;
      logic       ls;
      logic       fs;
   } obs_t;

   vga_sync_gen_if if_s ();
   vga_sync_gen_if if_p ();
   vga_sync_gen_if if_f ();
   assign if_s.EN = en;
   assign if_p.EN = en;
   assign if_f.EN = en;

   vga_sync_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                  .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                  .HS_POL(1'b0), .VS_POL(1'b0))
      dut_s (.CLK(CLK), .RST(RST), .vif(if_s.master));

   vga_sync_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                  .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
                  .HS_POL(1'b1), .VS_POL(1'b1))
      dut_p (.CLK(CLK), .RST(RST), .vif(if_p.master));

   vga_sync_gen dut_f (.CLK(CLK), .RST(RST), .vif(if_f.master));

   obs_t act [3];
   assign act[0] = {if_s.HSYNC, if_s.VSYNC, if_s.ACTIVE, if_s.BLANK, if_s.X, if_s.Y,
                    if_s.LINE_START, if_s.FRAME_START};
   assign act[1] = {if_p.HSYNC, if_p.VSYNC, if_p.ACTIVE, if_p.BLANK, if_p.X, if_p.Y,
                    if_p.LINE_START, if_p.FRAME_START};
   assign act[2] = {if_f.HSYNC, if_f.VSYNC, if_f.ACTIVE, if_f.BLANK, if_f.X, if_f.Y,
                    if_f.LINE_START, if_f.FRAME_START};

   int checks = 0;
   int errors = 0;

   obs_t sbq [3][$];
   int   pix [3];
   obs_t last [3];

   // Raster position expressed as a linear pixel index within the frame.
   function automatic obs_t decode(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                   input bit hp, vp, input int p);
      obs_t e;
      int ht, x, y;
      ht = ha + hf + hsw + hb;
      x  = p % ht;
      y  = p / ht;
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.act   = (x < ha) && (y < va);
      e.blank = !e.act;
      e.hs    = ((x >= ha + hf) && (x < ha + hf + hsw)) ? hp : !hp;
      e.vs    = ((y >= va + vf) && (y < va + vf + vsw)) ? vp : !vp;
      e.ls    = (x == 0);
      e.fs    = (p == 0);
      return e;
   endfunction

   function automatic obs_t model(input int d, input int p);
      case (d)
         0:       return decode(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, 1'b0, p);
         1:       return decode(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b1, p);
         default: return decode(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, p);
      endcase
   endfunction

   function automatic int frame_len(input int d);
      return (d == 2) ? 800 * 525 : (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
   endfunction

   function automatic obs_t rst_val(input int d);
      obs_t e;
      e       = '0;
      e.blank = 1'b1;
      e.hs    = (d == 1) ? 1'b0 : 1'b1;
      e.vs    = (d == 1) ? 1'b0 : 1'b1;
      return e;
   endfunction

   task automatic compare(input string name, input int d, input obs_t a, input obs_t e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s dut%0d got x=%0d y=%0d hs=%b vs=%b act=%b blk=%b ls=%b fs=%b want x=%0d y=%0d hs=%b vs=%b act=%b blk=%b ls=%b fs=%b",
                  name, d, a.x, a.y, a.hs, a.vs, a.act, a.blank, a.ls, a.fs,
                  e.x, e.y, e.hs, e.vs, e.act, e.blank, e.ls, e.fs);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         sbq[d].delete();
         pix[d]  = 0;
         last[d] = rst_val(d);
      end
   endtask

   // Monitor: every clock edge produces one observable output state per instance.
   obs_t mon_e;
   always @(posedge CLK) begin
      #1;
      for (int d = 0; d < 3; d++) begin
         if (sbq[d].size() > 0) begin
            mon_e = sbq[d].pop_front();
            compare("cycle", d, act[d], mon_e);
         end
      end
   end

   initial begin
      RST = 1'b1;
      en  = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 3; d++) compare("reset_init", d, act[d], rst_val(d));
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge CLK);
         if (cyc == 1700 || cyc == 3300) begin
            RST = 1'b1;
            #1;
            for (int d = 0; d < 3; d++) compare("reset_async", d, act[d], rst_val(d));
            model_reset();
         end
         if (cyc == 1703 || cyc == 3302) RST = 1'b0;

         if (cyc >= 600 && cyc < 637)
            en = 1'b0;
         else if (cyc < 40 || (cyc >= 1703 && cyc < 1710))
            en = 1'b1;
         else
            en = ($urandom_range(0, 7) != 0);

         for (int d = 0; d < 3; d++) begin
            if (!RST && en) begin
               last[d] = model(d, pix[d]);
               pix[d]  = (pix[d] + 1) % frame_len(d);
            end
            sbq[d].push_back(last[d]);
         end
      end

      @(posedge CLK);
      #3;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (sbq[d].size() != 0) begin
            errors++;
            $display("FAIL drain dut%0d got %0d pending want 0", d, sbq[d].size());
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
